vga_sync_decoder: RTL and testbench

//  Receive-side counterpart of the VGA timing generator: samples incoming active-low

---
 rtl/vga_sync_decoder.sv | 163 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - rebuilds VGA column/row/visible from incoming active-low syncs
// and reports lock once line and frame periods match the configured timing.
module vga_sync_decoder #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_WHOLE_LINE  = 800,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_WHOLE_FRAME = 525,
  parameter int LOCK_LINES    = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [9:0] column_o,
  output logic [9:0] row_o,
  output logic       visible_o,
  output logic       locked_o,
  output logic       sync_err_o
);

  localparam int HPW = $clog2(2 * H_WHOLE_LINE + 1);
  localparam int VLW = $clog2(V_WHOLE_FRAME + 2);
  localparam int LCW = $clog2(LOCK_LINES + 1);
  localparam logic [HPW-1:0] HPER_MAX   = HPW'(2 * H_WHOLE_LINE);
  localparam logic [HPW-1:0] HPER_GOOD  = HPW'(H_WHOLE_LINE - 1);
  localparam logic [VLW-1:0] VLINES_MAX = VLW'(V_WHOLE_FRAME + 1);

  if (H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE >= H_WHOLE_LINE ||
      V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE >= V_WHOLE_FRAME) begin : g_bad_timing
    $error("vga_sync_decoder: sync pulse does not fit inside the line or frame");
  end

  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;
  state_t state, state_nxt;

  logic           hs_q, vs_q;
  logic [HPW-1:0] hper;
  logic [VLW-1:0] vlines;
  logic [LCW-1:0] good_cnt, good_cnt_nxt;
  logic           first_pending, first_pending_nxt;
  logic           armed, armed_nxt;
  logic           err_nxt;
  logic           hfall, vfall, col_wrap;
  logic           line_good, line_bad, frame_good, frame_over;
  logic [9:0]     col_nxt, row_nxt;
  logic           visible_nxt;

  assign hfall      = hs_q & ~hsync_i;
  assign vfall      = vs_q & ~vsync_i;
  assign col_wrap   = !hfall && (column_o == 10'(H_WHOLE_LINE - 1));
  // A timeout is flagged once, on the cycle hper climbs onto its saturation value.
  assign line_good  = hfall && !first_pending && (hper == HPER_GOOD);
  assign line_bad   = (hfall && !first_pending && (hper != HPER_GOOD)) ||
                      (!hfall && (hper == HPER_MAX - HPW'(1)));
  assign frame_good = vfall && (vlines == VLW'(V_WHOLE_FRAME));
  assign frame_over = hfall && !vfall && (vlines == VLW'(V_WHOLE_FRAME));

  always_comb begin
    col_nxt = column_o + 10'd1;
    if (hfall)
      col_nxt = 10'(H_VISIBLE + H_FRONT_PORCH);
    else if (col_wrap)
      col_nxt = '0;

    row_nxt = row_o;
    if (vfall)
      row_nxt = 10'(V_VISIBLE + V_FRONT_PORCH);
    else if (col_wrap)
      row_nxt = (row_o == 10'(V_WHOLE_FRAME - 1)) ? '0 : row_o + 10'd1;
  end

  always_comb begin
    state_nxt         = state;
    good_cnt_nxt      = good_cnt;
    first_pending_nxt = first_pending;
    armed_nxt         = armed;
    err_nxt           = 1'b0;
    if (hfall)
      first_pending_nxt = 1'b0;
    case (state)
      SEARCH: begin
        if (line_bad)
          good_cnt_nxt = '0;
        else if (line_good) begin
          if (good_cnt == LCW'(LOCK_LINES - 1)) begin
            state_nxt    = HLOCK;
            good_cnt_nxt = '0;
            armed_nxt    = 1'b0;
          end else
            good_cnt_nxt = good_cnt + LCW'(1);
        end
      end
      HLOCK: begin
        if (line_bad) begin
          state_nxt         = SEARCH;
          first_pending_nxt = 1'b1;
        end else if (vfall) begin
          // Any vfall becomes the reference for the next frame measurement.
          if (armed && frame_good)
            state_nxt = LOCKED;
          armed_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (line_bad || (vfall && !frame_good) || frame_over) begin
          state_nxt         = SEARCH;
          first_pending_nxt = 1'b1;
          err_nxt           = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign visible_nxt = (state_nxt == LOCKED) && (col_nxt < 10'(H_VISIBLE)) &&
                       (row_nxt < 10'(V_VISIBLE));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hper          <= '0;
      vlines        <= '0;
      good_cnt      <= '0;
      first_pending <= 1'b1;
      armed         <= 1'b0;
      column_o      <= '0;
      row_o         <= '0;
      visible_o     <= 1'b0;
      locked_o      <= 1'b0;
      sync_err_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      hs_q          <= hsync_i;
      vs_q          <= vsync_i;
      good_cnt      <= good_cnt_nxt;
      first_pending <= first_pending_nxt;
      armed         <= armed_nxt;
      column_o      <= col_nxt;
      row_o         <= row_nxt;
      visible_o     <= visible_nxt;
      locked_o      <= (state_nxt == LOCKED);
      sync_err_o    <= err_nxt;

      if (hfall)
        hper <= '0;
      else if (hper != HPER_MAX)
        hper <= hper + HPW'(1);

      // An hfall coinciding with vfall is the first line of the new frame.
      if (vfall)
        vlines <= hfall ? VLW'(1) : '0;
      else if (hfall && (vlines != VLINES_MAX))
        vlines <= vlines + VLW'(1);
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder driven by a small
// behavioural VGA sync source (16x10 timing so whole frames stay short).
module tb_vga_sync_decoder;

  localparam int HV = 8, HF = 2, HS = 3, HW = 16;
  localparam int VV = 6, VF = 1, VS = 2, VW = 10;
  localparam int LL = 4;
  localparam int FRAME = HW * VW;
  // Second vsync fall is pixel (VV+VF)*HW + FRAME = 272, seen at edge 273.
  localparam int LOCK_EDGE = 273;

  logic       clk = 1'b0;
  logic       reset_i, hsync_i, vsync_i;
  logic [9:0] column_o, row_o;
  logic       visible_o, locked_o, sync_err_o;

  int vectors = 0, miscompares = 0;
  int hc, vc, prev_hc, prev_vc, cyc;
  int errs, err_cyc, err_locked, base, at;
  bit hmask, vmask, stretch, found;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_WHOLE_LINE(HW),
    .V_VISIBLE(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_WHOLE_FRAME(VW),
    .LOCK_LINES(LL)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .column_o(column_o), .row_o(row_o), .visible_o(visible_o),
    .locked_o(locked_o), .sync_err_o(sync_err_o)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    hsync_i = hmask || !(hc >= HV + HF && hc < HV + HF + HS);
    vsync_i = vmask || !(vc >= VV + VF && vc < VV + VF + VS);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    prev_hc = hc;
    prev_vc = vc;
    cyc++;
    if (sync_err_o) begin
      errs++;
      if (err_cyc < 0) begin
        err_cyc    = cyc;
        err_locked = locked_o;
      end
    end
    if (stretch)
      stretch = 1'b0;
    else if (hc == HW - 1) begin
      hc = 0;
      vc = (vc == VW - 1) ? 0 : vc + 1;
    end else
      hc++;
    drive();
  endtask

  task automatic clear_errs();
    errs = 0;
    err_cyc = -1;
    err_locked = -1;
    base = cyc;
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    hmask = 0; vmask = 0; stretch = 0;
    hc = 0; vc = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_column", column_o, 0);
    check_eq("reset_row", row_o, 0);
    check_eq("reset_visible", visible_o, 0);
    check_eq("reset_locked", locked_o, 0);
    check_eq("reset_sync_err", sync_err_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_lock(input int budget, output int edge_at);
    edge_at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (locked_o) begin
        edge_at = cyc;
        break;
      end
    end
  endtask

  // v < 0 matches any row
  task automatic wait_pix(input int h, input int v, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (hc == h && (v < 0 || vc == v)) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    clear_errs();

    // Lock from common reset
    apply_reset();
    clear_errs();
    wait_lock(2 * LOCK_EDGE, at);
    check_eq("lock_edge", at, LOCK_EDGE);
    check_eq("lock_no_err", errs, 0);

    // Full frame against the source delayed one cycle
    for (int i = 0; i < FRAME; i++) begin
      check_eq("frame_column", column_o, prev_hc);
      check_eq("frame_row", row_o, prev_vc);
      check_eq("frame_visible", visible_o, (prev_hc < HV && prev_vc < VV) ? 1 : 0);
      tick();
    end
    check_eq("frame_still_locked", locked_o, 1);
    check_eq("frame_no_err", errs, 0);

    // One 17-cycle line
    wait_pix(5, -1, found);
    check_eq("stretch_find", found, 1);
    clear_errs();
    stretch = 1;
    repeat (40) tick();
    check_eq("stretch_err_pulses", errs, 1);
    check_eq("stretch_err_offset", err_cyc - base, 7);
    check_eq("stretch_err_locked", err_locked, 0);
    check_eq("stretch_unlocked", locked_o, 0);
    wait_lock(4 * FRAME, at);
    check_eq("stretch_relock", locked_o, 1);

    // hsync held high for more than two lines
    wait_pix(HV + HF + 1, 0, found);
    check_eq("timeout_find", found, 1);
    clear_errs();
    hmask = 1;
    drive();
    repeat (40) tick();
    hmask = 0;
    drive();
    check_eq("timeout_err_pulses", errs, 1);
    check_eq("timeout_err_offset", err_cyc - base, 2 * HW);
    check_eq("timeout_unlocked", locked_o, 0);
    wait_lock(4 * FRAME, at);
    check_eq("timeout_relock", locked_o, 1);

    // One vsync pulse suppressed
    wait_pix(0, 1, found);
    check_eq("vmiss_find", found, 1);
    clear_errs();
    vmask = 1;
    drive();
    repeat (200) tick();
    vmask = 0;
    drive();
    check_eq("vmiss_err_pulses", errs, 1);
    check_eq("vmiss_err_offset", err_cyc - base, 107);
    check_eq("vmiss_unlocked", locked_o, 0);
    wait_lock(4 * FRAME, at);
    check_eq("vmiss_relock", locked_o, 1);

    // Asynchronous reset mid-row
    wait_pix(4, 3, found);
    check_eq("areset_find", found, 1);
    check_eq("areset_pre_locked", locked_o, 1);
    check_eq("areset_pre_visible", visible_o, 1);
    #3;
    reset_i = 1'b1;
    #1;
    check_eq("areset_column", column_o, 0);
    check_eq("areset_row", row_o, 0);
    check_eq("areset_visible", visible_o, 0);
    check_eq("areset_locked", locked_o, 0);
    apply_reset();
    clear_errs();
    wait_lock(2 * LOCK_EDGE, at);
    check_eq("areset_lock_edge", at, LOCK_EDGE);
    check_eq("areset_no_err", errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
